// File: rtl/mips_alu_control_fsm.sv
// Multicycle ALU control sequencer: DECODE/EXEC/MEM/MD_WAIT/WB, then a one-cycle done pulse.
// Latency accept->done: 2 (BEQ/J), 3 (ALU), 2+MD_CYCLES (MUL/DIV), 3+w (SW) / 4+w (LW).
// Backpressure: instr_ready only in IDLE; MEM holds its strobe until mem_ready, with no timeout.
module mips_alu_control_fsm #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst_rd,
  output logic       mem_to_reg,
  output logic       hilo_write,
  output logic       pc_write,
  output logic       branch_taken,
  output logic       done,
  output logic       illegal_op,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_MD_WAIT, S_WB
  } state_t;

  // Instruction class, resolved once at accept so later states only look at a flop.
  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_MUL, C_DIV, C_LW, C_SW, C_BEQ, C_J, C_ADDI, C_ILL
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  function automatic cls_t decode_cls(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    c = C_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   c = C_ADD;
          6'h22:   c = C_SUB;
          6'h18:   c = C_MUL;
          6'h1A:   c = C_DIV;
          default: c = C_ILL;
        endcase
      end
      6'h23:   c = C_LW;
      6'h2B:   c = C_SW;
      6'h04:   c = C_BEQ;
      6'h02:   c = C_J;
      6'h08:   c = C_ADDI;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_code(input cls_t c);
    logic [2:0] a;
    case (c)
      C_SUB:   a = 3'b001;
      C_MUL:   a = 3'b010;
      C_DIV:   a = 3'b011;
      C_LW:    a = 3'b100;
      C_SW:    a = 3'b101;
      C_BEQ:   a = 3'b110;
      C_J:     a = 3'b111;
      default: a = 3'b000;  // ADD, ADDI, and illegal (no operation issued)
    endcase
    return a;
  endfunction

  // Gated with rst_n so the fetch side sees no acceptance while reset is held.
  assign instr_ready = (state_q == S_IDLE) && rst_n;
  assign accept      = instr_valid && instr_ready;

  // State, latched class and MUL/DIV counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and strobe decode from registered state and latched class.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    cnt_d        = cnt_q;
    alu_op       = 3'b000;
    alu_src_imm  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst_rd   = 1'b0;
    mem_to_reg   = 1'b0;
    hilo_write   = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    illegal_op   = 1'b0;
    busy         = (state_q != S_IDLE);

    if (state_q != S_IDLE) begin
      alu_op      = alu_code(cls_q);
      alu_src_imm = (cls_q == C_ADDI) || (cls_q == C_LW) || (cls_q == C_SW);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cls_d   = decode_cls(opcode, funct);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls_q == C_ILL) begin
          illegal_op = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_MUL, C_DIV: begin
            cnt_d   = CNT_LOAD;
            state_d = S_MD_WAIT;
          end
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            branch_taken = alu_zero;
            done         = 1'b1;
            state_d      = S_IDLE;
          end
          C_J: begin
            pc_write = 1'b1;
            done     = 1'b1;
            state_d  = S_IDLE;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (cls_q == C_LW);
        mem_write = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MD_WAIT: begin
        if (cnt_q == '0) begin
          hilo_write = 1'b1;
          done       = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst_rd = (cls_q == C_ADD) || (cls_q == C_SUB);
        mem_to_reg = (cls_q == C_LW);
        done       = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_alu_control_fsm.sv
// Scoreboard bench for mips_alu_control_fsm: per-cycle expected output vectors are queued per instruction.
module tb_mips_alu_control_fsm;

  localparam int MDC = 4;

  // Flag bit positions within the 10-bit strobe field.
  localparam logic [9:0] F_MR   = 10'b10_0000_0000;
  localparam logic [9:0] F_MW   = 10'b01_0000_0000;
  localparam logic [9:0] F_RW   = 10'b00_1000_0000;
  localparam logic [9:0] F_RD   = 10'b00_0100_0000;
  localparam logic [9:0] F_M2R  = 10'b00_0010_0000;
  localparam logic [9:0] F_HILO = 10'b00_0001_0000;
  localparam logic [9:0] F_PCW  = 10'b00_0000_1000;
  localparam logic [9:0] F_BT   = 10'b00_0000_0100;
  localparam logic [9:0] F_DONE = 10'b00_0000_0010;
  localparam logic [9:0] F_ILL  = 10'b00_0000_0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic       alu_src_imm, mem_read, mem_write, reg_write, reg_dst_rd, mem_to_reg;
  logic       hilo_write, pc_write, branch_taken, done, illegal_op, busy;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic        mr_q[$];
  logic [15:0] obs;

  mips_alu_control_fsm #(.MD_CYCLES(MDC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg),
    .hilo_write(hilo_write), .pc_write(pc_write), .branch_taken(branch_taken),
    .done(done), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {instr_ready, busy, alu_op, alu_src_imm, mem_read, mem_write, reg_write,
                reg_dst_rd, mem_to_reg, hilo_write, pc_write, branch_taken, done, illegal_op};

  function automatic logic [15:0] vec(input logic ir, input logic bz, input logic [2:0] op,
                                      input logic imm, input logic [9:0] f);
    return {ir, bz, op, imm, f};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Build the expected trace for one instruction, starting with the IDLE cycle in which it is offered.
  task automatic push_model(input logic [5:0] op, input logic [5:0] fn, input logic az, input int w);
    logic [2:0] a;
    logic       imm, ill, rtype;
    a = 3'b000; imm = 1'b0; ill = 1'b0; rtype = 1'b0;
    if (op == 6'h00) begin
      rtype = 1'b1;
      if (fn == 6'h20) a = 3'b000;
      else if (fn == 6'h22) a = 3'b001;
      else if (fn == 6'h18) a = 3'b010;
      else if (fn == 6'h1A) a = 3'b011;
      else ill = 1'b1;
    end else if (op == 6'h23) begin a = 3'b100; imm = 1'b1; end
    else if (op == 6'h2B) begin a = 3'b101; imm = 1'b1; end
    else if (op == 6'h04) a = 3'b110;
    else if (op == 6'h02) a = 3'b111;
    else if (op == 6'h08) begin a = 3'b000; imm = 1'b1; end
    else ill = 1'b1;

    exp_q.push_back(vec(1, 0, 3'b000, 0, 10'd0)); mr_q.push_back(1'b0);
    if (ill) begin
      exp_q.push_back(vec(0, 1, 3'b000, 0, F_ILL)); mr_q.push_back(1'b0);
      return;
    end
    exp_q.push_back(vec(0, 1, a, imm, 10'd0)); mr_q.push_back(1'b0);   // DECODE
    case (a)
      3'b110: begin
        exp_q.push_back(vec(0, 1, a, imm, F_DONE | (az ? F_BT : 10'd0))); mr_q.push_back(1'b0);
      end
      3'b111: begin
        exp_q.push_back(vec(0, 1, a, imm, F_DONE | F_PCW)); mr_q.push_back(1'b0);
      end
      3'b010, 3'b011: begin
        exp_q.push_back(vec(0, 1, a, imm, 10'd0)); mr_q.push_back(1'b0);
        for (int i = 0; i < MDC; i++) begin
          exp_q.push_back(vec(0, 1, a, imm, (i == MDC - 1) ? (F_HILO | F_DONE) : 10'd0));
          mr_q.push_back(1'b0);
        end
      end
      3'b100, 3'b101: begin
        exp_q.push_back(vec(0, 1, a, imm, 10'd0)); mr_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
          exp_q.push_back(vec(0, 1, a, imm, (a == 3'b100) ? F_MR : F_MW)); mr_q.push_back(1'b0);
        end
        if (a == 3'b100) begin
          exp_q.push_back(vec(0, 1, a, imm, F_MR)); mr_q.push_back(1'b1);
          exp_q.push_back(vec(0, 1, a, imm, F_RW | F_M2R | F_DONE)); mr_q.push_back(1'b0);
        end else begin
          exp_q.push_back(vec(0, 1, a, imm, F_MW | F_DONE)); mr_q.push_back(1'b1);
        end
      end
      default: begin
        exp_q.push_back(vec(0, 1, a, imm, 10'd0)); mr_q.push_back(1'b0);
        exp_q.push_back(vec(0, 1, a, imm, F_RW | F_DONE | (rtype ? F_RD : 10'd0)));
        mr_q.push_back(1'b0);
      end
    endcase
  endtask

  // Offer one instruction and compare every cycle against the queued trace.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic az, input int w);
    int n;
    push_model(op, fn, az, w);
    n = 0;
    instr_valid = 1'b1; opcode = op; funct = fn; alu_zero = az;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      mem_ready = mr_q.pop_front();
      #1;
      chk($sformatf("%s_c%0d", tag, n), obs, exp_q.pop_front());
      n++;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      opcode = 6'($urandom);
      funct  = 6'($urandom);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    // Reset state while held.
    #2;
    chk("rst_hold", obs & 16'h7FFF, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_idle", obs, vec(1, 0, 3'b000, 0, 10'd0));
    @(posedge clk); #1;

    run_instr("add",   6'h00, 6'h20, 1'b0, 0);
    run_instr("sub",   6'h00, 6'h22, 1'b1, 0);
    run_instr("addi",  6'h08, 6'h15, 1'b0, 0);
    run_instr("mul",   6'h00, 6'h18, 1'b0, 0);
    run_instr("div",   6'h00, 6'h1A, 1'b1, 0);
    run_instr("lw_w2", 6'h23, 6'h00, 1'b0, 2);
    run_instr("lw_w0", 6'h23, 6'h3F, 1'b0, 0);
    run_instr("sw_w1", 6'h2B, 6'h00, 1'b0, 1);
    run_instr("sw_w0", 6'h2B, 6'h20, 1'b1, 0);
    run_instr("beq_t", 6'h04, 6'h00, 1'b1, 0);
    run_instr("beq_n", 6'h04, 6'h00, 1'b0, 0);
    run_instr("j",     6'h02, 6'h00, 1'b0, 0);
    run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 0);
    run_instr("ill_fn", 6'h00, 6'h21, 1'b0, 0);
    run_instr("add2",  6'h00, 6'h20, 1'b1, 0);

    // Reset asserted in the middle of MD_WAIT.
    @(negedge clk);
    instr_valid = 1'b1; opcode = 6'h00; funct = 6'h18;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("mdw_busy", obs, vec(0, 1, 3'b010, 0, 10'd0));
    rst_n = 1'b0;
    #1;
    chk("mdw_rst", obs & 16'h7FFF, 16'h0000);
    @(posedge clk); #1;
    chk("mdw_rst_hold", obs & 16'h7FFF, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mdw_rel", obs, vec(1, 0, 3'b000, 0, 10'd0));
    @(posedge clk); #1;
    run_instr("add_post", 6'h00, 6'h20, 1'b0, 0);
    run_instr("mul_post", 6'h00, 6'h18, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
